unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the pipeline's instruction-fetch (I) port and MEM-stage data (D) port.
//  Arbitrates, latches one request at a time, waits a variable-latency memory handshake and returns data with a done pulse.
//  Bounds I-side starvation and times out a dead memory.
//  Provides i_stall/d_stall to the hazard unit; these are ORed into StallF and the MEM-stall path.
// PARAMETERS
//  MAX_STARVE  4   consecutive D grants while I waits, after which I wins the next arbitration
//  TIMEOUT     64  cycles in BUSY without mem_ack before the access is abandoned with error
//  CNT_W       7   width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1   clock, rising edge
//  clr        in   1   synchronous active-high reset
//  i_req      in   1   fetch request; held until i_done
//  i_addr     in   32  fetch byte address (PCF)
//  i_rdata    out  32  fetched instruction, valid when i_done
//  i_done     out  1   one-cycle completion pulse, I side
//  i_stall    out  1   i_req & ~i_done
//  d_req      in   1   data request; held until d_done
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   32  data byte address (ALUResultM)
//  d_wdata    in   32  store data (WriteDataM)
//  d_be       in   4   store byte enables
//  d_rdata    out  32  load data, valid when d_done
//  d_done     out  1   one-cycle completion pulse, D side
//  d_stall    out  1   d_req & ~d_done
//  err        out  1   one-cycle pulse with done when access timed out
//  mem_req    out  1   memory request; held until mem_ack
//  mem_we     out  1   write strobe to memory
//  mem_addr   out  32  word address {addr[31:2],2'b00}
//  mem_wdata  out  32  write data
//  mem_be     out  4   byte enables; 4'b1111 for I-side and for loads
//  mem_ack    in   1   memory completion, one cycle; mem_rdata valid same cycle
//  mem_rdata  in   32  memory read data
// BEHAVIOUR
//  Reset (clr): state IDLE, starve_cnt=0, tmo_cnt=0, all outputs 0; clr wins over every other event.
//  Reset mid-transaction abandons the access: mem_req is 0 on the cycle after clr, and no done pulse occurs.
//  States: IDLE, BUSY_I, BUSY_D, RESP.
//  IDLE: arbitrate on sampled reqs. D wins unless (i_req && starve_cnt==MAX_STARVE).
//   On a grant: latch addr/wdata/be/we into output regs, go to BUSY_x; mem_req=1 from next cycle.
//   With no request, stay in IDLE with mem_req=0.
//  starve_cnt: +1 on a D grant while i_req=1, saturating at MAX_STARVE; cleared on any I grant or when i_req=0 in IDLE.
//  BUSY_x: mem_req and latched fields are held stable; tmo_cnt increments each cycle.
//   On mem_ack: register mem_rdata into x_rdata, go to RESP.
//   If tmo_cnt reaches TIMEOUT-1 without ack: drop mem_req, x_rdata=32'h0, set err, go to RESP.
//  mem_ack outside BUSY is ignored.
//  RESP: x_done=1 (and err if timed out) for exactly one cycle; mem_req=0; tmo_cnt cleared; next state IDLE.
//   Requests are not sampled in RESP, so the requester drops or renews its req here.
//  Minimum latency: request seen in IDLE cycle N -> mem_req at N+1 -> ack at N+1 earliest -> done at N+2.
//  Stores: d_rdata is unchanged on a store completion.
//  I side never writes: mem_we=0, mem_be=4'b1111.
//  Simultaneous i_req and d_req with starve_cnt<MAX_STARVE -> D granted, I stays stalled.
//  Requests arriving during BUSY/RESP wait; no queueing beyond the held req lines.
//  Outputs are registered except i_stall/d_stall, which are combinational.
// TESTING
//  Single fetch: i_req, i_addr=0x104, ack 1 cycle later with rdata 0x00500093 -> mem_addr=0x104; i_done at cycle 2 with i_rdata=0x00500093.
//  Store: d_req, d_we=1, d_addr=0x2003, d_be=4'b1000, d_wdata=0xAB000000 -> mem_addr=0x2000, mem_be=1000, mem_we=1; d_done.
//  Starvation: i_req and d_req held high, MAX_STARVE=4 -> grant order D,D,D,D,I,D...; starve_cnt back to 0 after the I grant.
//  Timeout: d_req, mem_ack never asserted -> after 64 BUSY cycles: err=1, d_done=1, d_rdata=0, mem_req=0.
//  Reset mid-access: clr asserted in BUSY_I -> next cycle mem_req=0, IDLE, no i_done.
//   A late mem_ack after the reset is ignored.
//  Back-to-back: D request renewed in RESP -> new grant in the following IDLE cycle; no double done.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the I-fetch, D-data and memory-side signals of the unified memory arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface unified_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-ported memory shared between instruction fetch and data access: one access in
// flight, D-priority with bounded I starvation, and a timeout that abandons a dead memory.
module unified_mem_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 7
) (
  input  logic                 clk,
  input  logic                 clr,
  unified_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic             err_q, err_d;
  logic             grant_i;
  logic             timed_out;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = '0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    err_d        = 1'b0;
    grant_i      = bus.i_req && (!bus.d_req || starve_cnt_q == SW'(MAX_STARVE));
    timed_out    = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

    case (state_q)
      IDLE: begin
        if (!bus.i_req) starve_cnt_d = '0;
        if (grant_i) begin
          state_d      = BUSY_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = {bus.i_addr[31:2], 2'b00};
          mem_wdata_d  = '0;
          mem_be_d     = 4'hF;
          starve_cnt_d = '0;
        end else if (bus.d_req) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = {bus.d_addr[31:2], 2'b00};
          mem_wdata_d = bus.d_wdata;
          mem_be_d    = bus.d_we ? bus.d_be : 4'hF;
          // D only wins over a waiting I below MAX_STARVE, so this never overflows
          if (bus.i_req) starve_cnt_d = starve_cnt_q + SW'(1);
        end
      end
      BUSY_I, BUSY_D: begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        if (bus.mem_ack || timed_out) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          tmo_cnt_d = '0;
          err_d     = !bus.mem_ack;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            d_done_d = 1'b1;
            if (!bus.mem_ack)  d_rdata_d = '0;
            else if (!mem_we_q) d_rdata_d = bus.mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  // Stalls stay combinational so the hazard unit releases in the done cycle itself
  assign bus.i_stall   = bus.i_req & ~i_done_q;
  assign bus.d_stall   = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: requester/memory drivers, a transaction-level
// arbitration model, and a negedge monitor that scores grants and done pulses.
module tb_unified_mem_arbiter;
  localparam int MAX_STARVE = 4;
  localparam int TIMEOUT    = 64;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  unified_mem_arbiter_if bus();

  unified_mem_arbiter #(.MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          side;   // 0 = I, 1 = D
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t        expq[$];
  bit          glog[$];
  int          starve;
  logic [31:0] d_rdata_m;
  bit          mon_en, mem_quiet, dead_next;
  int          dead_pct, fix_lat;
  bit          fix_rd_en;
  logic [31:0] fix_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_done(input bit side, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(side ? bus.d_done : bus.i_done) && n < 300);
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: no done on side %0d after %0d cycles", side, n);
    end
  endtask

  task automatic drv_i(input int n, input int maxgap);
    int c, g;
    for (int k = 0; k < n; k++) begin
      bus.i_addr = $urandom & 32'h7FFF_FFFF;
      bus.i_req  = 1'b1;
      wait_done(1'b0, c);
      g = $urandom_range(maxgap, 0);
      if (k == n - 1 || g != 0) begin
        bus.i_req = 1'b0;
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
      end
    end
  endtask

  task automatic drv_d(input int n, input int maxgap);
    int c, g;
    for (int k = 0; k < n; k++) begin
      bus.d_we    = 1'($urandom_range(1, 0));
      bus.d_addr  = 32'h8000_0000 | $urandom;
      bus.d_wdata = $urandom;
      bus.d_be    = 4'($urandom_range(15, 1));
      bus.d_req   = 1'b1;
      wait_done(1'b1, c);
      g = $urandom_range(maxgap, 0);
      if (k == n - 1 || g != 0) begin
        bus.d_req = 1'b0;
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
      end
    end
  endtask

  // Monitor, reference model and memory responder
  initial begin
    exp_t        e;
    bit          s_exp, s_act, dead, active, dead_cur, ireq_p, dreq_p, mreq_p;
    int          lat, ack_cd;
    logic [31:0] rd, rd_cur;
    active = 0; ireq_p = 0; dreq_p = 0; mreq_p = 0; ack_cd = 0; rd_cur = '0; dead_cur = 0;
    starve = 0; d_rdata_m = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (clr) begin
        expq.delete();
        active = 0; starve = 0; d_rdata_m = '0;
        ireq_p = 0; dreq_p = 0; mreq_p = 0;
        if (!mem_quiet) bus.mem_ack = 1'b0;
        continue;
      end

      check("i_stall", bus.i_stall, bus.i_req & ~bus.i_done);
      check("d_stall", bus.d_stall, bus.d_req & ~bus.d_done);

      if (bus.i_done || bus.d_done || bus.err) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done: unexpected i_done=%b d_done=%b err=%b", bus.i_done, bus.d_done, bus.err);
        end else begin
          e = expq.pop_front();
          check("done_flags", {bus.i_done, bus.d_done, bus.err, bus.mem_req},
                {!e.side, e.side, e.err, 1'b0});
          check(e.side ? "d_rdata" : "i_rdata", e.side ? bus.d_rdata : bus.i_rdata, e.rdata);
          check("done_cycle", cyc, e.cyc);
          active = 0;
        end
      end else if (expq.size() > 0 && cyc > expq[0].cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL done: missing pulse, due cycle %0d now %0d", expq[0].cyc, cyc);
        void'(expq.pop_front());
        active = 0;
      end

      if (bus.mem_req && !mreq_p) begin
        s_act = (bus.mem_addr[31:2] == bus.d_addr[31:2]);
        glog.push_back(s_act);
        if (!ireq_p && !dreq_p) begin
          vectors++;
          miscompares++;
          $display("FAIL grant: mem_req rose with no request pending");
        end
        // D wins unless I has already been passed over MAX_STARVE times in a row
        s_exp = !(ireq_p && (!dreq_p || starve == MAX_STARVE));
        if (ireq_p && s_exp) starve = (starve < MAX_STARVE) ? starve + 1 : MAX_STARVE;
        else starve = 0;
        check("grant_side", s_act, s_exp);
        if (!s_exp)
          check("mem_fields_i", {bus.mem_we, bus.mem_be, bus.mem_addr},
                {1'b0, 4'hF, bus.i_addr[31:2], 2'b00});
        else begin
          check("mem_fields_d", {bus.mem_we, bus.mem_be, bus.mem_addr},
                {bus.d_we, bus.d_we ? bus.d_be : 4'hF, bus.d_addr[31:2], 2'b00});
          if (bus.d_we) check("mem_wdata", bus.mem_wdata, bus.d_wdata);
        end
        dead = dead_next || ($urandom_range(99, 0) < dead_pct);
        dead_next = 0;
        rd  = fix_rd_en ? fix_rd : $urandom;
        lat = (fix_lat >= 0) ? fix_lat : $urandom_range(4, 0);
        e.side = s_exp;
        e.err  = dead;
        if (dead) begin
          e.rdata = '0;
          e.cyc   = cyc + TIMEOUT;
          if (s_exp) d_rdata_m = '0;
        end else begin
          e.cyc = cyc + lat + 1;
          if (!s_exp) e.rdata = rd;
          else if (bus.d_we) e.rdata = d_rdata_m;
          else begin e.rdata = rd; d_rdata_m = rd; end
        end
        expq.push_back(e);
        active = 1; dead_cur = dead; ack_cd = lat; rd_cur = rd;
      end

      if (!mem_quiet) begin
        if (active && !dead_cur) begin
          if (ack_cd == 0) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = rd_cur; active = 0;
          end else begin
            bus.mem_ack = 1'b0; bus.mem_rdata = $urandom; ack_cd--;
          end
        end else if (active) begin
          bus.mem_ack = 1'b0;
        end else begin
          // stray acks while no access is in flight must be ignored
          bus.mem_ack   = ($urandom_range(4, 0) == 0);
          bus.mem_rdata = $urandom;
        end
      end
      ireq_p = bus.i_req; dreq_p = bus.d_req; mreq_p = bus.mem_req;
    end
  end

  initial begin
    int          n;
    logic [14:0] order;
    clr = 1'b1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    mon_en = 0; mem_quiet = 0; dead_next = 0; dead_pct = 0; fix_lat = -1; fix_rd_en = 0; fix_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {bus.mem_req, bus.mem_we, bus.mem_be, bus.i_done, bus.d_done, bus.err}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    @(posedge clk); #1;
    clr = 1'b0; mon_en = 1;

    // single fetch, ack in the first BUSY cycle
    fix_lat = 0; fix_rd_en = 1; fix_rd = 32'h0050_0093;
    bus.i_addr = 32'h104; bus.i_req = 1'b1;
    wait_done(1'b0, n);
    check("fetch_latency", n, 2);
    check("fetch_rdata", bus.i_rdata, 32'h0050_0093);
    bus.i_req = 1'b0; fix_rd_en = 0;
    @(posedge clk); #1;

    // byte store to an unaligned address
    fix_lat = 2;
    bus.d_we = 1'b1; bus.d_addr = 32'h2003; bus.d_be = 4'b1000; bus.d_wdata = 32'hAB00_0000;
    bus.d_req = 1'b1;
    wait_done(1'b1, n);
    check("store_latency", n, 4);
    check("store_rdata_kept", bus.d_rdata, 0);
    bus.d_req = 1'b0; fix_lat = -1;
    @(posedge clk); #1;

    // both sides saturating: four D grants then one I, repeating
    glog.delete();
    fork
      drv_i(3, 0);
      drv_d(12, 0);
    join
    for (int k = 0; k < 15; k++) order[14-k] = (k < glog.size()) ? glog[k] : 1'bx;
    check("starve_order", order, 15'b111101111011110);
    @(posedge clk); #1;

    // dead memory on a load
    dead_next = 1;
    bus.d_we = 1'b0; bus.d_addr = 32'h8000_0040; bus.d_req = 1'b1;
    wait_done(1'b1, n);
    check("tmo_latency", n, TIMEOUT + 1);
    check("tmo_err_rdata", {bus.err, bus.d_rdata}, {1'b1, 32'h0});
    bus.d_req = 1'b0;
    @(posedge clk); #1;

    // reset while a fetch is in BUSY, then a late ack
    mem_quiet = 1; bus.mem_ack = 1'b0; dead_next = 1;
    bus.i_addr = 32'h40; bus.i_req = 1'b1;
    n = 0;
    while (!bus.mem_req && n < 10) begin @(posedge clk); #1; n++; end
    check("rst_busy_req", bus.mem_req, 1);
    @(posedge clk); #1;
    clr = 1'b1; bus.i_req = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    check("rst_drop_req", bus.mem_req, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    repeat (4) begin
      check("rst_idle", {bus.mem_req, bus.i_done, bus.err, bus.i_rdata}, 0);
      @(posedge clk); #1;
    end
    mem_quiet = 0;

    // random mix with gaps, back-to-back renewals and occasional dead accesses
    dead_pct = 3;
    fork
      drv_i(30, 3);
      drv_d(30, 3);
    join
    dead_pct = 0;
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
